// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_if
// Description : Fetch-to-decode handshake bundle for the instruction queue.
//               The master side is fetch/decode (the environment); the slave
//               side is the queue itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [31:0]        in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [31:0]        out_instr;
  logic [24:0]        out_imm;
  logic [6:0]         out_opcode;
  logic [c_CNT_W-1:0] count;

  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_imm, out_opcode, count
  );

  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_imm, out_opcode, count
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Circular FIFO of {PC, instruction} pairs between fetch and
//               decode. Head is read combinationally with NOP defaults when
//               empty; flush discards everything in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  wire logic       clk,
  input  wire logic       reset,
  fetch_queue_if.slave    bus
);
  localparam int                 c_PTR_W = $clog2(DEPTH);
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);
  localparam logic [31:0]        c_NOP   = 32'h0000_0013;

  logic [PC_W-1:0]    r_mem_pc    [DEPTH];
  logic [31:0]        r_mem_instr [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_push;
  logic               w_pop;
  logic [31:0]        w_head_instr;

  // Handshake status depends only on the registered occupancy.
  assign w_in_ready  = (r_count != c_FULL);
  assign w_out_valid = (r_count != '0);
  // Flush wins over both transfers in the same cycle.
  assign w_push      = bus.in_valid  && w_in_ready  && !bus.flush;
  assign w_pop       = bus.out_ready && w_out_valid && !bus.flush;

  // Pointer and occupancy bookkeeping; reset and flush both empty the queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage is not reset; stale slots are never visible because the
  // head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= bus.in_pc;
      r_mem_instr[r_wr_ptr] <= bus.in_instr;
    end
  end

  // Head presentation: entry at rd_ptr, or the NOP/zero defaults when empty.
  always_comb begin
    w_head_instr = c_NOP;
    bus.out_pc   = '0;
    if (w_out_valid) begin
      w_head_instr = r_mem_instr[r_rd_ptr];
      bus.out_pc   = r_mem_pc[r_rd_ptr];
    end
  end

  assign bus.out_instr  = w_head_instr;
  assign bus.out_imm    = w_head_instr[31:7];
  assign bus.out_opcode = w_head_instr[6:0];
  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.count      = r_count;
endmodule
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Instruction queue between the fetch stage and the decode stage of the RV32IM pipeline. Buffers fetched {PC, instruction} pairs in a small circular FIFO so instruction-memory latency and decode stalls are decoupled. It presents the head instruction to decode, including the raw 25-bit immediate field (instr[31:7]) that feeds the decode-stage sign extender. A single-cycle flush discards all queued entries on a taken branch or jump.

## Interface
- DEPTH, 4: number of entries; power of two, at least 2.
- PC_W, 32: PC width.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- flush  in  1  synchronous discard of all entries (redirect from execute).
- in_valid  in  1  fetch presents an entry.
- in_ready  out  1  queue can accept an entry; equals (count != DEPTH).
- in_pc  in  PC_W  PC of the fetched instruction.
- in_instr  in  32  fetched instruction word.
- out_valid  out  1  head entry valid; equals (count != 0).
- out_ready  in  1  decode consumes the head this cycle (low = decode stall).
- out_pc  out  PC_W  head PC; 0 when empty.
- out_instr  out  32  head instruction; 32'h00000013 (addi x0,x0,0 NOP) when empty.
- out_imm  out  25  out_instr[31:7]; immediate source for decode.
- out_opcode  out  7  out_instr[6:0].
- count  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH-entry arrays for PC and instruction, indexed by write and read pointers of log2(DEPTH) bits. Pointers wrap modulo DEPTH. Storage is not reset.
- Push: in_valid && in_ready. Writes in_pc and in_instr at wr_ptr, then increments wr_ptr.
- Pop: out_valid && out_ready. Increments rd_ptr.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on simultaneous push and pop.
- Full (count == DEPTH): in_ready is low, so no push occurs. A pop in the same cycle frees a slot for the next cycle only; there is no same-cycle refill.
- Empty (count == 0):
  - out_valid is low.
  - out_pc, out_instr, out_imm and out_opcode show the NOP/zero defaults.
  - There is no combinational bypass from in_* to out_*.
- Head outputs are combinational reads of the entry at rd_ptr, muxed with the empty defaults.
- Flush has priority over push and pop. Pointers and count return to 0, and any push or pop in the flush cycle is ignored.
- Order is strictly preserved (FIFO). No entry is duplicated or dropped except by flush or reset.
- in_valid while in_ready is low is legal; fetch holds its entry, and no state changes from it.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - wr_ptr = rd_ptr = count = 0.
  - out_valid = 0, in_ready = 1.
  - out_instr = 32'h00000013, out_pc = 0, out_imm = 0, out_opcode = 7'h13.
- Reset mid-operation drops all entries immediately, without waiting for a clock edge.
- Latency: an entry pushed at edge N is visible on out_* with out_valid = 1 after edge N.
- Throughput: 1 entry/cycle sustained when in_valid and out_ready are both held high.
- Flush asserted in cycle N: after edge N, count = 0, out_valid = 0 and in_ready = 1. A push in cycle N+1 is accepted normally.
- in_ready and out_valid are functions of registered count only; there are no combinational paths from in_valid or out_ready.

## Test plan
- Reset/default: assert reset with 3 entries queued.
  - Required: count = 0, out_valid = 0, out_instr = 0x00000013, out_imm = 0, in_ready = 1, all without a clock edge.
- Fill/full: out_ready = 0, push PCs 0x00, 0x04, 0x08, 0x0C.
  - Required: count = 4 and in_ready = 0 after the 4th push.
  - A 5th in_valid with PC 0x10 is not accepted.
  - Then one pop gives out_pc = 0x00, and in_ready = 1 on the next cycle.
- Immediate field: push instr 0xFFF00093.
  - Required, next cycle: out_instr = 0xFFF00093, out_imm = 0x1FFE001, out_opcode = 0x13.
- Streaming: in_valid = out_ready = 1 for 12 cycles with PCs 0x100 + 4k.
  - Required: out_valid from the cycle after the first push, one entry per cycle in order, count stays at 1.
  - This also exercises pointer wrap-around (12 > DEPTH).
- Flush collision: with 2 entries queued, assert flush together with in_valid (PC 0x200) and out_ready.
  - Required: count = 0 and out_valid = 0 next cycle.
  - PC 0x200 never appears.
  - A following push of PC 0x300 appears alone at the head.
- Random push/pop: random in_valid and out_ready for 2000 cycles against a reference-queue model.
  - Required: exact order match, count matches the model, no push while full, no pop while empty.
